// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB with wait-state tolerant memory
// handshakes, and drives the datapath selects, write strobes and counters.
module mc_ctrl_unit #(
    parameter int ALUOP_W      = 5,
    parameter int NPCOP_W      = 4,
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic [4:0]         bgez_bltz,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic               IRWr,
    output logic               MDRWr,
    output logic               PCWr,
    output logic               RFWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         ToReg,
    output logic [1:0]         ALUSrc,
    output logic               ALUSrc0,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [NPCOP_W-1:0] NPCOp,
    output logic [1:0]         DMWr,
    output logic [2:0]         DMRe,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret,
    output logic [CNT_W-1:0]   cycles
);
    // Datapath select encodings shared with the datapath
    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
    localparam logic [1:0] DM2REG = 2'd0, ALU2REG = 2'd1, NPC2REG = 2'd2;
    localparam logic [1:0] ALUSRC_ZERO = 2'd0, ALUSRC_REG = 2'd1, ALUSRC_IMM = 2'd2;
    localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SW = 2'd1, DMWR_SH = 2'd2, DMWR_SB = 2'd3;
    localparam logic [2:0] DMRE_NOP = 3'd0, DMRE_LW = 3'd1, DMRE_LH = 3'd2,
                           DMRE_LHU = 3'd3, DMRE_LB = 3'd4, DMRE_LBU = 3'd5;
    localparam logic [NPCOP_W-1:0] NPC_PLUS4 = NPCOP_W'(0), NPC_BRANCH_BEQ = NPCOP_W'(1),
        NPC_BRANCH_BNE = NPCOP_W'(2), NPC_BRANCH_BGTZ = NPCOP_W'(3),
        NPC_BRANCH_BLEZ = NPCOP_W'(4), NPC_BRANCH_BLTZ = NPCOP_W'(5),
        NPC_BRANCH_BGEZ = NPCOP_W'(6), NPC_JUMP = NPCOP_W'(7), NPC_JR = NPCOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(0), ALU_ADD = ALUOP_W'(1),
        ALU_ADDU = ALUOP_W'(2), ALU_SUB = ALUOP_W'(3), ALU_SUBU = ALUOP_W'(4),
        ALU_AND = ALUOP_W'(5), ALU_OR = ALUOP_W'(6), ALU_XOR = ALUOP_W'(7),
        ALU_NOR = ALUOP_W'(8), ALU_SLT = ALUOP_W'(9), ALU_SLTU = ALUOP_W'(10),
        ALU_SLL = ALUOP_W'(11), ALU_SRL = ALUOP_W'(12), ALU_SRA = ALUOP_W'(13),
        ALU_LUI = ALUOP_W'(14);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } st_t;

    // Instruction class decides the FSM path after DECODE
    typedef enum logic [2:0] {
        CL_ILL, CL_JUMP, CL_LINK, CL_BR, CL_LD, CL_ST, CL_ALU
    } cls_t;

    st_t                cur;
    cls_t               cls;
    logic [1:0]         d_regdst, d_toreg, d_alusrc, d_dmwr;
    logic [2:0]         d_dmre;
    logic               d_alusrc0, d_extop, sel_on;
    logic [ALUOP_W-1:0] d_aluop;
    logic [NPCOP_W-1:0] d_npcop;

    // Instruction decode: class plus the select values for this instruction
    always_comb begin
        cls       = CL_ILL;
        d_regdst  = RD_RT;
        d_toreg   = DM2REG;
        d_alusrc  = ALUSRC_ZERO;
        d_alusrc0 = 1'b0;
        d_extop   = 1'b0;
        d_aluop   = ALU_NOP;
        d_npcop   = NPC_PLUS4;
        d_dmwr    = DMWR_NOP;
        d_dmre    = DMRE_NOP;
        case (op)
            6'h00: begin
                cls = CL_ALU;
                case (funct)
                    6'h20: d_aluop = ALU_ADD;
                    6'h21: d_aluop = ALU_ADDU;
                    6'h22: d_aluop = ALU_SUB;
                    6'h23: d_aluop = ALU_SUBU;
                    6'h24: d_aluop = ALU_AND;
                    6'h25: d_aluop = ALU_OR;
                    6'h26: d_aluop = ALU_XOR;
                    6'h27: d_aluop = ALU_NOR;
                    6'h2A: d_aluop = ALU_SLT;
                    6'h2B: d_aluop = ALU_SLTU;
                    6'h00: begin d_aluop = ALU_SLL; d_alusrc0 = 1'b1; end
                    6'h02: begin d_aluop = ALU_SRL; d_alusrc0 = 1'b1; end
                    6'h03: begin d_aluop = ALU_SRA; d_alusrc0 = 1'b1; end
                    6'h04: d_aluop = ALU_SLL;
                    6'h06: d_aluop = ALU_SRL;
                    6'h07: d_aluop = ALU_SRA;
                    6'h08: begin cls = CL_JUMP; d_npcop = NPC_JR; end
                    6'h09: begin
                        cls = CL_LINK; d_npcop = NPC_JR;
                        d_regdst = RD_RD; d_toreg = NPC2REG;
                    end
                    default: cls = CL_ILL;
                endcase
                // register-register ALU ops write rd from the ALU
                if (cls == CL_ALU) begin
                    d_regdst = RD_RD;
                    d_toreg  = ALU2REG;
                    d_alusrc = ALUSRC_REG;
                end
            end
            6'h02: begin cls = CL_JUMP; d_npcop = NPC_JUMP; end
            6'h03: begin
                cls = CL_LINK; d_npcop = NPC_JUMP;
                d_regdst = RD_RA; d_toreg = NPC2REG;
            end
            6'h04: begin cls = CL_BR; d_alusrc = ALUSRC_REG; d_aluop = ALU_SUB; d_npcop = NPC_BRANCH_BEQ; end
            6'h05: begin cls = CL_BR; d_alusrc = ALUSRC_REG; d_aluop = ALU_SUB; d_npcop = NPC_BRANCH_BNE; end
            6'h06: begin cls = CL_BR; d_aluop = ALU_SUB; d_npcop = NPC_BRANCH_BLEZ; end
            6'h07: begin cls = CL_BR; d_aluop = ALU_SUB; d_npcop = NPC_BRANCH_BGTZ; end
            6'h01: begin
                d_aluop = ALU_SUB;
                if (bgez_bltz == 5'd0)      begin cls = CL_BR; d_npcop = NPC_BRANCH_BLTZ; end
                else if (bgez_bltz == 5'd1) begin cls = CL_BR; d_npcop = NPC_BRANCH_BGEZ; end
                else                        d_aluop = ALU_NOP;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                cls      = CL_ALU;
                d_toreg  = ALU2REG;
                d_alusrc = ALUSRC_IMM;
                d_extop  = (op <= 6'h0B);
                case (op[2:0])
                    3'd0:    d_aluop = ALU_ADD;
                    3'd1:    d_aluop = ALU_ADDU;
                    3'd2:    d_aluop = ALU_SLT;
                    3'd3:    d_aluop = ALU_SLTU;
                    3'd4:    d_aluop = ALU_AND;
                    3'd5:    d_aluop = ALU_OR;
                    3'd6:    d_aluop = ALU_XOR;
                    default: d_aluop = ALU_LUI;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                cls = CL_LD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_aluop = ALU_ADD;
                case (op)
                    6'h20:   d_dmre = DMRE_LB;
                    6'h21:   d_dmre = DMRE_LH;
                    6'h24:   d_dmre = DMRE_LBU;
                    6'h25:   d_dmre = DMRE_LHU;
                    default: d_dmre = DMRE_LW;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin
                cls = CL_ST; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_aluop = ALU_ADD;
                case (op)
                    6'h28:   d_dmwr = DMWR_SB;
                    6'h29:   d_dmwr = DMWR_SH;
                    default: d_dmwr = DMWR_SW;
                endcase
            end
            default: cls = CL_ILL;
        endcase
    end

    // State-gated strobes and selects; strobes are suppressed while rst is high
    always_comb begin
        sel_on   = (cur == S_DECODE) || (cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB);
        imem_req = (cur == S_FETCH);
        dmem_req = (cur == S_MEM);
        IRWr     = !rst && (cur == S_FETCH) && imem_ack;
        illegal  = !rst && (cur == S_DECODE) && (cls == CL_ILL);
        MDRWr    = !rst && (cur == S_MEM) && (cls == CL_LD) && dmem_ack;
        RFWr     = !rst && (cur == S_WB);
        PCWr     = !rst && (((cur == S_DECODE) && ((cls == CL_JUMP) ||
                                ((cls == CL_ILL) && (ILLEGAL_HALT == 0)))) ||
                            ((cur == S_EXEC) && (cls == CL_BR)) ||
                            ((cur == S_MEM) && (cls == CL_ST) && dmem_ack) ||
                            (cur == S_WB));
        RegDst   = sel_on ? d_regdst  : RD_RT;
        ToReg    = sel_on ? d_toreg   : DM2REG;
        ALUSrc   = sel_on ? d_alusrc  : ALUSRC_ZERO;
        ALUSrc0  = sel_on ? d_alusrc0 : 1'b0;
        EXTOp    = sel_on ? d_extop   : 1'b0;
        ALUOp    = sel_on ? d_aluop   : ALU_NOP;
        NPCOp    = sel_on ? d_npcop   : NPC_PLUS4;
        DMWr     = dmem_req ? d_dmwr : DMWR_NOP;
        DMRe     = dmem_req ? d_dmre : DMRE_NOP;
    end

    assign state = cur;

    // Sequencer, halt flag and retire/cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            halted  <= 1'b0;
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (cur != S_HALT) cycles <= cycles + CNT_W'(1);
            if (PCWr)          instret <= instret + CNT_W'(1);
            case (cur)
                S_FETCH:  if (imem_ack) cur <= S_DECODE;
                S_DECODE: begin
                    case (cls)
                        CL_JUMP: cur <= S_FETCH;
                        CL_LINK: cur <= S_WB;
                        CL_ILL: begin
                            if (ILLEGAL_HALT != 0) begin
                                cur    <= S_HALT;
                                halted <= 1'b1;
                            end else begin
                                cur <= S_FETCH;
                            end
                        end
                        default: cur <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        CL_BR:        cur <= S_FETCH;
                        CL_LD, CL_ST: cur <= S_MEM;
                        default:      cur <= S_WB;
                    endcase
                end
                S_MEM: if (dmem_ack) cur <= (cls == CL_LD) ? S_WB : S_FETCH;
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed checks of the multi-cycle control unit.
// dut_a uses default parameters; dut_b runs ILLEGAL_HALT=0 with 4-bit counters.
module tb_mc_ctrl_unit;
    logic clk = 1'b0;
    logic rst, imem_ack, dmem_ack;
    logic [5:0] op, funct;
    logic [4:0] bgez_bltz;

    logic imem_req_a, dmem_req_a, IRWr_a, MDRWr_a, PCWr_a, RFWr_a, ALUSrc0_a, EXTOp_a;
    logic halted_a, illegal_a;
    logic [1:0] RegDst_a, ToReg_a, ALUSrc_a, DMWr_a;
    logic [2:0] DMRe_a, state_a;
    logic [4:0] ALUOp_a;
    logic [3:0] NPCOp_a;
    logic [31:0] instret_a, cycles_a;

    logic imem_req_b, dmem_req_b, IRWr_b, MDRWr_b, PCWr_b, RFWr_b, ALUSrc0_b, EXTOp_b;
    logic halted_b, illegal_b;
    logic [1:0] RegDst_b, ToReg_b, ALUSrc_b, DMWr_b;
    logic [2:0] DMRe_b, state_b;
    logic [4:0] ALUOp_b;
    logic [3:0] NPCOp_b;
    logic [3:0] instret_b, cycles_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_ctrl_unit dut_a (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .bgez_bltz(bgez_bltz),
        .imem_req(imem_req_a), .imem_ack(imem_ack), .dmem_req(dmem_req_a), .dmem_ack(dmem_ack),
        .IRWr(IRWr_a), .MDRWr(MDRWr_a), .PCWr(PCWr_a), .RFWr(RFWr_a),
        .RegDst(RegDst_a), .ToReg(ToReg_a), .ALUSrc(ALUSrc_a), .ALUSrc0(ALUSrc0_a),
        .EXTOp(EXTOp_a), .ALUOp(ALUOp_a), .NPCOp(NPCOp_a), .DMWr(DMWr_a), .DMRe(DMRe_a),
        .state(state_a), .halted(halted_a), .illegal(illegal_a),
        .instret(instret_a), .cycles(cycles_a)
    );

    mc_ctrl_unit #(.CNT_W(4), .ILLEGAL_HALT(0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .bgez_bltz(bgez_bltz),
        .imem_req(imem_req_b), .imem_ack(imem_ack), .dmem_req(dmem_req_b), .dmem_ack(dmem_ack),
        .IRWr(IRWr_b), .MDRWr(MDRWr_b), .PCWr(PCWr_b), .RFWr(RFWr_b),
        .RegDst(RegDst_b), .ToReg(ToReg_b), .ALUSrc(ALUSrc_b), .ALUSrc0(ALUSrc0_b),
        .EXTOp(EXTOp_b), .ALUOp(ALUOp_b), .NPCOp(NPCOp_b), .DMWr(DMWr_b), .DMRe(DMRe_b),
        .state(state_b), .halted(halted_b), .illegal(illegal_b),
        .instret(instret_b), .cycles(cycles_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are then driven and outputs read well after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        op = 6'h00; funct = 6'h00; bgez_bltz = 5'd0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_state", state_a, 0);
        chk("rst_imem_req", imem_req_a, 1);
        chk("rst_dmem_req", dmem_req_a, 0);
        chk("rst_strobes", {IRWr_a, MDRWr_a, PCWr_a, RFWr_a}, 0);
        chk("rst_sel", {NPCOp_a, ALUOp_a, DMRe_a, DMWr_a, RegDst_a, ALUSrc_a}, 0);
        chk("rst_instret", instret_a, 0);
        chk("rst_cycles", cycles_a, 0);
        chk("rst_halted", halted_a, 0);

        // ADDU $3,$1,$2 with zero-wait fetch
        imem_ack = 1'b1; op = 6'h00; funct = 6'h21; #1;
        chk("addu_irwr", IRWr_a, 1);
        tick(); imem_ack = 1'b0; #1;
        chk("addu_st_dec", state_a, 1);
        chk("addu_dec_aluop", ALUOp_a, 2);
        chk("addu_dec_pcwr", PCWr_a, 0);
        tick(); #1;
        chk("addu_st_exec", state_a, 2);
        tick(); #1;
        chk("addu_st_wb", state_a, 4);
        chk("addu_wb_rfwr", RFWr_a, 1);
        chk("addu_wb_pcwr", PCWr_a, 1);
        chk("addu_wb_regdst", RegDst_a, 1);
        chk("addu_wb_toreg", ToReg_a, 1);
        chk("addu_wb_aluop", ALUOp_a, 2);
        tick(); #1;
        chk("addu_instret", instret_a, 1);
        chk("addu_cycles", cycles_a, 4);

        // LW with dmem_ack two cycles late
        imem_ack = 1'b1; op = 6'h23; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("lw_exec_dmre_nop", DMRe_a, 0);
        tick(); #1;
        chk("lw_m1_req", dmem_req_a, 1);
        chk("lw_m1_dmre", DMRe_a, 1);
        chk("lw_m1_mdrwr", MDRWr_a, 0);
        tick(); #1;
        chk("lw_m2_req", dmem_req_a, 1);
        chk("lw_m2_dmre", DMRe_a, 1);
        tick(); dmem_ack = 1'b1; #1;
        chk("lw_m3_req", dmem_req_a, 1);
        chk("lw_m3_dmre", DMRe_a, 1);
        chk("lw_m3_mdrwr", MDRWr_a, 1);
        tick(); dmem_ack = 1'b0; #1;
        chk("lw_wb_state", state_a, 4);
        chk("lw_wb_rfwr", RFWr_a, 1);
        chk("lw_wb_toreg", ToReg_a, 0);
        chk("lw_wb_req", dmem_req_a, 0);
        tick(); #1;
        chk("lw_instret", instret_a, 2);
        chk("lw_cycles", cycles_a, 11);

        // SW then BEQ, zero-wait
        imem_ack = 1'b1; op = 6'h2B; #1;
        tick(); imem_ack = 1'b0; #1;
        chk("sw_dec_rfwr", RFWr_a, 0);
        tick(); #1;
        chk("sw_exec_rfwr", RFWr_a, 0);
        tick(); dmem_ack = 1'b1; #1;
        chk("sw_mem_state", state_a, 3);
        chk("sw_mem_pcwr", PCWr_a, 1);
        chk("sw_mem_rfwr", RFWr_a, 0);
        chk("sw_mem_dmwr", DMWr_a, 1);
        tick(); dmem_ack = 1'b0; imem_ack = 1'b1; op = 6'h04; #1;
        chk("beq_fetch_state", state_a, 0);
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("beq_exec_pcwr", PCWr_a, 1);
        chk("beq_exec_npcop", NPCOp_a, 1);
        tick(); #1;
        chk("swbeq_instret", instret_a, 4);
        chk("swbeq_cycles", cycles_a, 18);

        // reset while MEM holds dmem_req
        imem_ack = 1'b1; op = 6'h23; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk("rmem_req_before", dmem_req_a, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; dmem_ack = 1'b1; #1;
        chk("rmem_state", state_a, 0);
        chk("rmem_req", dmem_req_a, 0);
        chk("rmem_instret", instret_a, 0);
        chk("rmem_cycles", cycles_a, 0);
        chk("rmem_strobes", {PCWr_a, MDRWr_a}, 0);
        tick(); dmem_ack = 1'b0; #1;
        chk("rmem_ack_ignored", state_a, 0);
        chk("rmem_cycles_run", cycles_a, 1);

        // illegal opcode 0x3F on both variants
        rst = 1'b1; tick(); rst = 1'b0;
        imem_ack = 1'b1; op = 6'h3F; funct = 6'h00; #1;
        tick(); imem_ack = 1'b0; #1;
        chk("ill_a_pulse", illegal_a, 1);
        chk("ill_a_pcwr", PCWr_a, 0);
        chk("ill_b_pulse", illegal_b, 1);
        chk("ill_b_pcwr", PCWr_b, 1);
        chk("ill_b_npcop", NPCOp_b, 0);
        tick(); #1;
        chk("ill_a_state", state_a, 5);
        chk("ill_a_halted", halted_a, 1);
        chk("ill_a_pulse_off", illegal_a, 0);
        chk("ill_a_cycles", cycles_a, 2);
        chk("ill_b_state", state_b, 0);
        chk("ill_b_instret", instret_b, 1);
        repeat (10) tick();
        #1;
        chk("halt_state", state_a, 5);
        chk("halt_cycles_frozen", cycles_a, 2);
        chk("halt_imem_req", imem_req_a, 0);
        chk("halt_halted", halted_a, 1);
        chk("halt_strobes", {IRWr_a, PCWr_a, RFWr_a, MDRWr_a, illegal_a}, 0);

        // sixteen J instructions: 4-bit counters wrap
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            imem_ack = 1'b1; op = 6'h02; #1;
            tick(); imem_ack = 1'b0; #1;
            if (i == 0) chk("j_dec_pcwr", PCWr_b, 1);
            tick(); #1;
            if (i == 14) begin
                chk("wrap_pre_instret", instret_b, 15);
                chk("wrap_pre_cycles", cycles_b, 14);
            end
        end
        chk("wrap_instret", instret_b, 0);
        chk("wrap_cycles", cycles_b, 0);
        chk("wrap_state", state_b, 0);
        chk("wrap_a_instret", instret_a, 16);
        chk("wrap_a_cycles", cycles_a, 32);

        // BGEZ / BLTZ selected by bgez_bltz
        imem_ack = 1'b1; op = 6'h01; bgez_bltz = 5'd1; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("bgez_pcwr", PCWr_a, 1);
        chk("bgez_npcop", NPCOp_a, 6);
        bgez_bltz = 5'd0; #1;
        chk("bltz_npcop", NPCOp_a, 5);
        tick(); #1;
        chk("bgez_fetch", state_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
